// File: rtl/digital_clock_ext_if.sv
// Control and time-of-day bus between the display/alarm logic and digital_clock_ext.
//   master : drives enable, load, mode and alarm controls; observes time and flags
//   slave  : the clock core; observes controls, drives time and flags
interface digital_clock_ext_if;
  logic       en;
  logic       load;
  logic [4:0] ld_hr;
  logic [5:0] ld_min;
  logic [5:0] ld_sec;
  logic       mode12;
  logic       alarm_en;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_clr;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       pm;
  logic       tick_sec;
  logic       load_err;
  logic       alarm;

  modport master (
    output en, load, ld_hr, ld_min, ld_sec, mode12,
           alarm_en, alarm_hr, alarm_min, alarm_clr,
    input  sec, min, hr, pm, tick_sec, load_err, alarm
  );

  modport slave (
    input  en, load, ld_hr, ld_min, ld_sec, mode12,
           alarm_en, alarm_hr, alarm_min, alarm_clr,
    output sec, min, hr, pm, tick_sec, load_err, alarm
  );
endinterface

// File: rtl/digital_clock_ext.sv
// Time-of-day counter with prescaler, count enable, range-checked load,
// 12/24-hour display and sticky alarm. The count is held in 24-hour form.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - digital_clock_ext_if.slave: en/load/ld_*/mode12/alarm_* in,
//          sec/min/hr/pm/tick_sec/load_err/alarm out (hr/pm combinational)
module digital_clock_ext #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned DIV_W    = 24
) (
  input  logic               clk,
  input  logic               rst,
  digital_clock_ext_if.slave bus
);

  localparam logic [DIV_W-1:0] LP_PRESC_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [4:0]       LP_HR_MAX     = 5'd23;
  localparam logic [5:0]       LP_MS_MAX     = 6'd59;
  localparam logic [4:0]       LP_HR_NOON    = 5'd12;

  logic [DIV_W-1:0] r_presc;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic [4:0]       r_hr24;
  logic             r_tick;
  logic             r_load_err;
  logic             r_alarm;

  logic             w_tick;
  logic             w_ld_ok;
  logic             w_do_load;
  logic             w_ld_bad;
  logic [5:0]       w_sec_n;
  logic [5:0]       w_min_n;
  logic [4:0]       w_hr_n;
  logic             w_alarm_set;
  logic [4:0]       w_hr_disp;

  assign w_tick    = bus.en && (r_presc == LP_PRESC_LAST);
  assign w_ld_ok   = (bus.ld_hr <= LP_HR_MAX) && (bus.ld_min <= LP_MS_MAX) &&
                     (bus.ld_sec <= LP_MS_MAX);
  assign w_do_load = bus.load && w_ld_ok;
  assign w_ld_bad  = bus.load && !w_ld_ok;

  // Time one second ahead, with seconds/minutes/hours carry chain
  always_comb begin
    w_sec_n = r_sec + 6'd1;
    w_min_n = r_min;
    w_hr_n  = r_hr24;
    if (r_sec == LP_MS_MAX) begin
      w_sec_n = 6'd0;
      w_min_n = r_min + 6'd1;
      if (r_min == LP_MS_MAX) begin
        w_min_n = 6'd0;
        w_hr_n  = (r_hr24 == LP_HR_MAX) ? 5'd0 : r_hr24 + 5'd1;
      end
    end
  end

  // Alarm fires only on a tick advance; out-of-range alarm fields cannot match
  // because the advanced time is always in range.
  assign w_alarm_set = w_tick && !w_do_load && bus.alarm_en &&
                       (w_hr_n == bus.alarm_hr) && (w_min_n == bus.alarm_min) &&
                       (w_sec_n == 6'd0);

  // Prescaler, time, and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      r_sec      <= 6'd0;
      r_min      <= 6'd0;
      r_hr24     <= 5'd0;
      r_tick     <= 1'b0;
      r_load_err <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_load_err <= w_ld_bad;
      r_alarm    <= w_alarm_set || (r_alarm && !bus.alarm_clr);
      if (w_do_load) begin
        r_presc <= '0;
        r_sec   <= bus.ld_sec;
        r_min   <= bus.ld_min;
        r_hr24  <= bus.ld_hr;
      end else if (w_tick) begin
        r_presc <= '0;
        r_sec   <= w_sec_n;
        r_min   <= w_min_n;
        r_hr24  <= w_hr_n;
        r_tick  <= 1'b1;
      end else if (bus.en) begin
        r_presc <= r_presc + DIV_W'(1);
      end
    end
  end

  // 12-hour mapping: 0 -> 12, 13..23 -> 1..11
  always_comb begin
    w_hr_disp = r_hr24;
    if (bus.mode12) begin
      if (r_hr24 == 5'd0) begin
        w_hr_disp = LP_HR_NOON;
      end else if (r_hr24 > LP_HR_NOON) begin
        w_hr_disp = r_hr24 - LP_HR_NOON;
      end
    end
  end

  assign bus.sec      = r_sec;
  assign bus.min      = r_min;
  assign bus.hr       = w_hr_disp;
  assign bus.pm       = (r_hr24 >= LP_HR_NOON);
  assign bus.tick_sec = r_tick;
  assign bus.load_err = r_load_err;
  assign bus.alarm    = r_alarm;

endmodule

// File: tb/tb_digital_clock_ext.sv
// Directed bench: one instance with TICK_DIV=1 (time/load/mode/alarm/reset)
// and one with TICK_DIV=4 (prescaler and enable hold).
module tb_digital_clock_ext;

  logic clk;
  logic rst1;
  logic rst4;
  int   n_cmp;
  int   n_err;

  digital_clock_ext_if if1 ();
  digital_clock_ext_if if4 ();

  digital_clock_ext #(.TICK_DIV(1), .DIV_W(24)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  digital_clock_ext #(.TICK_DIV(4), .DIV_W(3)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time1(input string tag, input logic [4:0] h, input logic [5:0] m,
                           input logic [5:0] s);
    chk({tag, ".hr"},  32'(if1.hr),  32'(h));
    chk({tag, ".min"}, 32'(if1.min), 32'(m));
    chk({tag, ".sec"}, 32'(if1.sec), 32'(s));
  endtask

  task automatic chk_flags1(input string tag, input logic tick, input logic lerr,
                            input logic alm);
    chk({tag, ".tick"},     32'(if1.tick_sec), 32'(tick));
    chk({tag, ".load_err"}, 32'(if1.load_err), 32'(lerr));
    chk({tag, ".alarm"},    32'(if1.alarm),    32'(alm));
  endtask

  task automatic chk4(input string tag, input logic [5:0] s, input logic tick);
    chk({tag, ".sec"},  32'(if4.sec),      32'(s));
    chk({tag, ".tick"}, 32'(if4.tick_sec), 32'(tick));
  endtask

  task automatic load1(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    if1.load   = 1'b1;
    if1.ld_hr  = h;
    if1.ld_min = m;
    if1.ld_sec = s;
    step();
    if1.load   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst1 = 1'b1;
    rst4 = 1'b1;
    if1.en = 1'b0; if1.load = 1'b0; if1.ld_hr = 5'd0; if1.ld_min = 6'd0; if1.ld_sec = 6'd0;
    if1.mode12 = 1'b0; if1.alarm_en = 1'b0; if1.alarm_hr = 5'd0; if1.alarm_min = 6'd0;
    if1.alarm_clr = 1'b0;
    if4.en = 1'b0; if4.load = 1'b0; if4.ld_hr = 5'd0; if4.ld_min = 6'd0; if4.ld_sec = 6'd0;
    if4.mode12 = 1'b0; if4.alarm_en = 1'b0; if4.alarm_hr = 5'd0; if4.alarm_min = 6'd0;
    if4.alarm_clr = 1'b0;
    step();
    step();

    // Reset state, both display modes
    chk_time1("rst", 5'd0, 6'd0, 6'd0);
    chk_flags1("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.pm", 32'(if1.pm), 32'd0);
    if1.mode12 = 1'b1;
    #1;
    chk("rst.hr12", 32'(if1.hr), 32'd12);
    if1.mode12 = 1'b0;
    chk4("rst4", 6'd0, 1'b0);

    // TICK_DIV=4: first tick on enabled edge 4, then edge 8
    rst4 = 1'b0;
    if4.en = 1'b1;
    step(); step(); step();
    chk4("p4.e3", 6'd0, 1'b0);
    step();
    chk4("p4.e4", 6'd1, 1'b1);
    step();
    chk4("p4.e5", 6'd1, 1'b0);
    step(); step();
    chk4("p4.e7", 6'd1, 1'b0);
    step();
    chk4("p4.e8", 6'd2, 1'b1);
    step(); step();
    // Hold for 3 cycles with prescaler at 2
    if4.en = 1'b0;
    step(); step(); step();
    chk4("p4.hold", 6'd2, 1'b0);
    if4.en = 1'b1;
    step();
    chk4("p4.resume1", 6'd2, 1'b0);
    step();
    chk4("p4.resume2", 6'd3, 1'b1);

    // TICK_DIV=1 rollover through midnight
    rst1 = 1'b0;
    load1(5'd23, 6'd59, 6'd58);
    chk_time1("roll.ld", 5'd23, 6'd59, 6'd58);
    chk_flags1("roll.ld", 1'b0, 1'b0, 1'b0);
    chk("roll.ld.pm", 32'(if1.pm), 32'd1);
    if1.en = 1'b1;
    step();
    chk_time1("roll.1", 5'd23, 6'd59, 6'd59);
    chk("roll.1.tick", 32'(if1.tick_sec), 32'd1);
    chk("roll.1.pm", 32'(if1.pm), 32'd1);
    step();
    chk_time1("roll.2", 5'd0, 6'd0, 6'd0);
    chk("roll.2.tick", 32'(if1.tick_sec), 32'd1);
    chk("roll.2.pm", 32'(if1.pm), 32'd0);

    // 12/24-hour display
    if1.en = 1'b0;
    load1(5'd0, 6'd0, 6'd0);
    if1.mode12 = 1'b1; #1;
    chk("m12.h0.hr", 32'(if1.hr), 32'd12);
    chk("m12.h0.pm", 32'(if1.pm), 32'd0);
    if1.mode12 = 1'b0; #1;
    chk("m24.h0.hr", 32'(if1.hr), 32'd0);
    load1(5'd12, 6'd0, 6'd0);
    if1.mode12 = 1'b1; #1;
    chk("m12.h12.hr", 32'(if1.hr), 32'd12);
    chk("m12.h12.pm", 32'(if1.pm), 32'd1);
    if1.mode12 = 1'b0; #1;
    chk("m24.h12.hr", 32'(if1.hr), 32'd12);
    load1(5'd13, 6'd5, 6'd0);
    if1.mode12 = 1'b1; #1;
    chk("m12.h13.hr", 32'(if1.hr), 32'd1);
    chk("m12.h13.pm", 32'(if1.pm), 32'd1);
    if1.mode12 = 1'b0; #1;
    chk_time1("m24.h13", 5'd13, 6'd5, 6'd0);

    // Rejected loads keep counting; valid load is exact
    if1.en = 1'b1;
    load1(5'd10, 6'd60, 6'd0);
    chk_time1("lerr.min", 5'd13, 6'd5, 6'd1);
    chk_flags1("lerr.min", 1'b1, 1'b1, 1'b0);
    step();
    chk_time1("lerr.after", 5'd13, 6'd5, 6'd2);
    chk("lerr.after.load_err", 32'(if1.load_err), 32'd0);
    load1(5'd24, 6'd0, 6'd0);
    chk_time1("lerr.hr", 5'd13, 6'd5, 6'd3);
    chk("lerr.hr.load_err", 32'(if1.load_err), 32'd1);
    load1(5'd10, 6'd20, 6'd30);
    chk_time1("ld.ok", 5'd10, 6'd20, 6'd30);
    chk_flags1("ld.ok", 1'b0, 1'b0, 1'b0);
    step();
    chk_time1("ld.next", 5'd10, 6'd20, 6'd31);
    chk("ld.next.tick", 32'(if1.tick_sec), 32'd1);

    // Alarm set, sticky, set-vs-clear, load never sets
    if1.alarm_en = 1'b1;
    if1.alarm_hr = 5'd7;
    if1.alarm_min = 6'd30;
    load1(5'd7, 6'd29, 6'd58);
    chk("alm.ld", 32'(if1.alarm), 32'd0);
    step();
    chk("alm.59", 32'(if1.alarm), 32'd0);
    step();
    chk_time1("alm.hit", 5'd7, 6'd30, 6'd0);
    chk("alm.hit.alarm", 32'(if1.alarm), 32'd1);
    step();
    chk("alm.sticky", 32'(if1.alarm), 32'd1);
    load1(5'd7, 6'd29, 6'd59);
    chk("alm.reload", 32'(if1.alarm), 32'd1);
    if1.alarm_clr = 1'b1;
    step();
    chk("alm.setwins", 32'(if1.alarm), 32'd1);
    step();
    chk("alm.cleared", 32'(if1.alarm), 32'd0);
    if1.alarm_clr = 1'b0;
    load1(5'd7, 6'd30, 6'd0);
    chk_time1("alm.direct", 5'd7, 6'd30, 6'd0);
    chk("alm.direct.alarm", 32'(if1.alarm), 32'd0);
    step();
    chk("alm.direct.next", 32'(if1.alarm), 32'd0);

    // Reset while running overrides load and clears the alarm
    if1.alarm_hr = 5'd5;
    if1.alarm_min = 6'd6;
    load1(5'd5, 6'd5, 6'd59);
    step();
    chk("rr.alarm", 32'(if1.alarm), 32'd1);
    load1(5'd5, 6'd6, 6'd7);
    chk_time1("rr.pre", 5'd5, 6'd6, 6'd7);
    rst1 = 1'b1;
    if1.alarm_clr = 1'b1;
    load1(5'd10, 6'd0, 6'd0);
    chk_time1("rr.rst", 5'd0, 6'd0, 6'd0);
    chk_flags1("rr.rst", 1'b0, 1'b0, 1'b0);
    rst1 = 1'b0;
    if1.alarm_clr = 1'b0;
    step();
    chk_time1("rr.resume", 5'd0, 6'd0, 6'd1);
    chk("rr.resume.tick", 32'(if1.tick_sec), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digital_clock_ext.md
# digital_clock_ext

Parametrised time-of-day counter, successor to the basic seconds/minutes/hours clock. Adds a configurable prescaler, count enable, synchronous time load with range checking, a 12/24-hour display mode and a sticky alarm. Sits between the board clock and the display/alarm logic; the internal count is always kept in 24-hour form.

## Interface
Parameters:
- TICK_DIV, default 1: clk cycles per second tick; legal range 1..2^24.
- DIV_W, default 24: prescaler counter width; must satisfy TICK_DIV ≤ 2^DIV_W.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; 0 freezes prescaler and time.
- load  in  1  one-cycle request to load ld_hr/ld_min/ld_sec.
- ld_hr  in  5  load hours, 24-h form, 0..23.
- ld_min  in  6  load minutes, 0..59.
- ld_sec  in  6  load seconds, 0..59.
- mode12  in  1  0 = 24-h display, 1 = 12-h display.
- alarm_en  in  1  alarm compare enable.
- alarm_hr  in  5  alarm hours, 24-h form.
- alarm_min  in  6  alarm minutes.
- alarm_clr  in  1  clears alarm flag.
- sec  out  6  seconds 0..59.
- min  out  6  minutes 0..59.
- hr  out  5  hours: 0..23 (mode12=0) or 1..12 (mode12=1).
- pm  out  1  1 when internal hour ≥ 12, independent of mode12.
- tick_sec  out  1  one-cycle pulse in the cycle a new seconds value first appears.
- load_err  out  1  one-cycle pulse when a load is rejected.
- alarm  out  1  sticky alarm flag.

## Operation
- Priority per edge: rst > load > tick advance.
- Reset: sec=0, min=0, hr24=0, prescaler=0, tick_sec=0, load_err=0, alarm=0. Output hr=0 (mode12=0) or 12 (mode12=1); pm=0.
- Prescaler: counts enabled cycles 0..TICK_DIV-1; at TICK_DIV-1 with en=1 wraps to 0 and generates a tick on that edge. en=0 holds prescaler and time unchanged.
- Tick advance: sec+1; sec 59→0 carries min+1; min 59→0 carries hr24+1; hr24 23→0. 23:59:59 → 00:00:00 in one edge.
- Load: if ld_hr≤23, ld_min≤59, ld_sec≤59, all three fields load and prescaler clears to 0; tick_sec stays 0 that cycle. Any field out of range: whole load rejected, time and prescaler advance as if load=0, load_err pulses one cycle. load is honoured regardless of en.
- Display: hr, pm are combinational from hr24 and mode12. 12-h mapping: 0→12, 1..12→same, 13..23→hr24-12. mode12 may change any cycle; no effect on the count.
- Alarm: set on the edge where a tick advance makes the time equal alarm_hr:alarm_min:00 while alarm_en=1. Loads never set alarm. alarm_clr clears alarm; if set and clear coincide, set wins. alarm stays high until alarm_clr or rst. alarm_hr/alarm_min out of range never match.

## Timing
- All outputs except hr/pm are registered; hr/pm add only combinational delay from registers.
- First tick after rst release with en held 1: edge number TICK_DIV; with TICK_DIV=1, every enabled edge ticks.
- tick_sec high exactly in the cycle the incremented sec is visible; never two consecutive cycles unless TICK_DIV=1.
- Load latency: values visible one cycle after the load edge; next tick TICK_DIV enabled edges later.
- alarm rises in the same cycle the matching time becomes visible.
- rst asserted mid-count: all state cleared at that edge; load or alarm_clr in the same cycle ignored.

## Test plan
- TICK_DIV=1, load 23:59:58, en=1 → 23:59:59, then 00:00:00 with tick_sec each cycle, pm 1→0.
- TICK_DIV=4, after rst, en=1 → sec=1 at edge 4, sec=2 at edge 8; en=0 for 3 cycles mid-count → sec and prescaler hold, tick delayed 3 cycles.
- mode12=1, load 00:00:00, 12:00:00, 13:05:00 → hr=12/pm=0, hr=12/pm=1, hr=1/pm=1; mode12=0 → hr=0, 12, 13.
- load ld_min=60 → time unchanged and still advancing, load_err one-cycle pulse; valid load 10:20:30 → exact values next cycle, load_err=0.
- alarm_en=1, alarm 07:30, load 07:29:58, TICK_DIV=1 → alarm rises when 07:30:00 appears, stays high; alarm_clr same cycle as a set keeps alarm=1; load 07:30:00 directly → alarm not set.
- rst pulse while running at 05:06:07 → next cycle 00:00:00, alarm=0, tick_sec=0; counting resumes per first-tick rule.
